// File: rtl/instr_word_encoder.sv
// instr_word_encoder
//
// Packs decoded instruction fields and a 64-bit sign-extended immediate back
// into a 32-bit RISC-V instruction word (inverse of the immediate generator),
// buffers up to two encoded words in a FIFO and tags each with a sequential
// word address.
//
// Optional feature macro: ENC_RANGE_CHECK_EN
//   defined   -> I/S/SB requests whose immediate does not fit in 12 signed
//                bits are flagged (out_err=1, err_count increments); the word
//                still carries the truncated imm[11:0].
//   undefined -> truncation is silent; only format 2'b10 is flagged.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   clear             synchronous flush of the FIFO and address counter
//   in_valid/in_ready request handshake
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//                     decoded instruction fields
//   out_valid/out_ready  head-word handshake
//   out_instr, out_addr, out_err  FIFO head: word, address tag, error flag
//   err_count         saturating count of flagged words accepted

module instr_word_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    // FIFO entry layout: {err, addr, instr}
    localparam int                ENTRY_W  = 33 + ADDR_W;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       NOP_WORD = 32'h0000_0013;

    logic [31:0] enc_instr;
    logic        enc_err;
    logic        imm_fmt;
    logic        range_bad;

    // Immediate fits in 12 signed bits only if bits 63:11 are all copies of
    // bit 11.
`ifdef ENC_RANGE_CHECK_EN
    assign range_bad = (in_imm[63:11] != {53{in_imm[11]}});
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[63:12];
    assign range_bad     = 1'b0;
`endif

    always_comb begin
        enc_instr = NOP_WORD;
        enc_err   = 1'b0;
        imm_fmt   = 1'b0;
        unique case (in_opcode[6:5])
            2'b00: begin
                enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                imm_fmt   = 1'b1;
            end
            2'b01: begin
                if (in_opcode[4]) begin
                    enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                end else begin
                    enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:0], in_opcode};
                    imm_fmt   = 1'b1;
                end
            end
            2'b11: begin
                // Branch: immediate is the halfword offset, not shifted.
                enc_instr = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3,
                             in_imm[3:0], in_imm[10], in_opcode};
                imm_fmt   = 1'b1;
            end
            default: begin
                enc_instr = NOP_WORD;
                enc_err   = 1'b1;
            end
        endcase
        if (imm_fmt && range_bad) begin
            enc_err = 1'b1;
        end
    end

    logic [ENTRY_W-1:0] mem_q [2];
    logic [ENTRY_W-1:0] mem_d [2];
    logic [1:0]         count_q, count_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               run_q, run_d;
    logic               push, pop;
    logic [ENTRY_W-1:0] head;

    // run_q holds in_ready low until the first edge after reset release.
    assign in_ready  = run_q && (count_q != 2'd2) && !clear;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !clear;

    assign head      = mem_q[rd_ptr_q];
    assign out_instr = out_valid ? head[31:0]           : 32'd0;
    assign out_addr  = out_valid ? head[ADDR_W+31:32]   : '0;
    assign out_err   = out_valid ? head[ENTRY_W-1]      : 1'b0;
    assign err_count = err_cnt_q;

    always_comb begin
        mem_d     = mem_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        addr_d    = addr_q;
        err_cnt_d = err_cnt_q;
        run_d     = 1'b1;

        if (clear) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            addr_d   = BASE;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {enc_err, addr_q, enc_instr};
                wr_ptr_d        = ~wr_ptr_q;
                addr_d          = addr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (!push && pop) begin
                count_d = count_q - 2'd1;
            end
        end

        // push is already blocked while clear is high.
        if (push && enc_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            addr_q    <= BASE;
            err_cnt_q <= 8'd0;
            run_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
            run_q     <= run_d;
        end
    end

    // Storage carries no reset; outputs are masked by out_valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_instr_word_encoder.sv
module tb_instr_word_encoder;

    localparam int ADDR_W = 8;
`ifdef ENC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [63:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [7:0]        err_count;

    always #5 clk = ~clk;

    instr_word_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  addr;
        logic        err;
        int          kind;   // 0 I, 1 S, 2 SB, 3 no immediate
        logic [63:0] imm;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   model_addr = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference encoder built from the field-placement rules with arithmetic.
    function automatic void model_enc(input logic [6:0] opc, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [63:0] imm,
                                      output logic [31:0] word, output logic err,
                                      output int kind);
        longint unsigned o  = 64'(opc);
        longint unsigned d  = 64'(rd);
        longint unsigned s1 = 64'(rs1);
        longint unsigned s2 = 64'(rs2);
        longint unsigned f  = 64'(f3);
        longint unsigned g  = 64'(f7);
        longint unsigned i12 = imm % 4096;
        longint unsigned w;
        int fmt = int'(opc) / 32;
        err  = 1'b0;
        kind = 3;
        case (fmt)
            0: begin
                w = (i12 << 20) | (s1 << 15) | (f << 12) | (d << 7) | o;
                kind = 0;
            end
            1: begin
                if ((int'(opc) / 16) % 2 == 1) begin
                    w = (g << 25) | (s2 << 20) | (s1 << 15) | (f << 12) | (d << 7) | o;
                end else begin
                    w = ((i12 / 32) << 25) | (s2 << 20) | (s1 << 15) | (f << 12)
                        | ((i12 % 32) << 7) | o;
                    kind = 1;
                end
            end
            3: begin
                w = ((i12 / 2048) << 31) | (((i12 / 16) % 64) << 25) | (s2 << 20)
                    | (s1 << 15) | (f << 12) | ((i12 % 16) << 8)
                    | (((i12 / 1024) % 2) << 7) | o;
                kind = 2;
            end
            default: begin
                w = 64'h13;
                err = 1'b1;
            end
        endcase
`ifdef ENC_RANGE_CHECK_EN
        begin
            bit in_range;
            in_range = ($signed(imm) >= -64'sd2048) && ($signed(imm) <= 64'sd2047);
            if (kind != 3 && !in_range) err = 1'b1;
        end
`endif
        word = w[31:0];
    endfunction

    // Immediate generator: recovers the sign-extended immediate from a word.
    function automatic logic [63:0] decode_imm(input logic [31:0] w, input int kind);
        logic [11:0] f;
        case (kind)
            0:       f = w[31:20];
            1:       f = {w[31:25], w[11:7]};
            default: f = {w[31], w[7], w[30:25], w[11:8]};
        endcase
        return {{52{f[11]}}, f};
    endfunction

    task automatic set_req(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [63:0] imm);
        in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    task automatic rand_req(input bit legal_only);
        logic [11:0] r;
        logic [63:0] imm;
        logic [6:0]  opc;
        r = 12'($urandom);
        case ($urandom % 4)
            0, 1: imm = {{52{r[11]}}, r};
            2:    imm = {$urandom, $urandom};
            default: begin
                case ($urandom % 4)
                    0: imm = 64'd2047;
                    1: imm = -64'sd2048;
                    2: imm = 64'd2048;
                    default: imm = -64'sd2049;
                endcase
            end
        endcase
        opc = 7'($urandom);
        if (legal_only) begin
            opc = {2'b00, opc[4:0]};
            imm = {{52{r[11]}}, r};
        end
        set_req(opc, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                7'($urandom), imm);
    endtask

    task automatic push_model();
        exp_t e;
        model_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
                  e.instr, e.err, e.kind);
        e.addr = 8'(model_addr);
        e.imm  = in_imm;
        exp_q.push_back(e);
        if (e.err && n_err < 255) n_err++;
        model_addr = (model_addr + 1) % 256;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit v, input bit ord, input bit clr, output bit acc);
        check("err_count", err_count, 64'(n_err));
        in_valid  = v;
        clear     = clr;
        out_ready = clr ? 1'b0 : ord;
        #1;
        check("in_ready", in_ready, (exp_q.size() < 2) && !clr);
        check("out_valid", out_valid, exp_q.size() != 0);
        acc = v && in_ready;
        if (clr) begin
            exp_q.delete();
            model_addr = 0;
        end else if (acc) begin
            push_model();
        end
        @(negedge clk);
    endtask

    // Monitor: compares the head word whenever it is consumed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", out_instr);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_instr", out_instr, e.instr);
                    check("sb_addr", out_addr, e.addr);
                    check("sb_err", out_err, e.err);
                    if (e.kind != 3)
                        check("imm_roundtrip", decode_imm(out_instr, e.kind),
                              {{52{e.imm[11]}}, e.imm[11:0]});
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        bit pend;
        int k;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_req(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_err", out_err, 0);
        check("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", in_ready, 0);
        @(negedge clk);

        // I-type
        set_req(7'b0000011, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, 64'hFFFF_FFFF_FFFF_FFF8);
        cycle(1, 0, 0, acc);
        check("i_accept", acc, 1);
        check("i_latency_valid", out_valid, 1);
        check("i_instr", out_instr, 32'hFF81_3283);
        check("i_addr", out_addr, 0);
        check("i_err", out_err, 0);
        // S-type
        set_req(7'b0100011, 5'd0, 5'd2, 5'd6, 3'd3, 7'd0, 64'd16);
        cycle(1, 0, 0, acc);
        cycle(0, 1, 0, acc);
        check("s_instr", out_instr, 32'h0061_3823);
        check("s_addr", out_addr, 1);
        cycle(0, 1, 0, acc);
        // SB-type
        set_req(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        cycle(1, 0, 0, acc);
        check("sbt_instr", out_instr, 32'hFE20_8EE3);
        check("sbt_imm_gen", decode_imm(out_instr, 2), 64'hFFFF_FFFF_FFFF_FFFE);
        cycle(0, 1, 0, acc);

        // Backpressure
        cycle(0, 0, 1, acc);
        for (int i = 0; i < 3; i++) begin
            rand_req(1'b1);
            cycle(1, 0, 0, acc);
            check("bp_accept", acc, i < 2);
        end
        k = 0;
        while (!acc && k < 10) begin
            cycle(1, 1, 0, acc);
            k++;
        end
        check("bp_third_accepted", acc, 1);
        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            cycle(0, 1, 0, acc);
            k++;
        end

        // Range
        set_req(7'b0000011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);
        cycle(1, 0, 0, acc);
        check("range_err", out_err, RC);
        check("range_imm_field", out_instr[31:20], 12'h800);
        cycle(0, 1, 0, acc);
        check("range_err_count", err_count, RC);
        set_req(7'b1010011, 5'd3, 5'd4, 5'd5, 3'd1, 7'd2, 64'd0);
        cycle(1, 0, 0, acc);
        check("unsup_instr", out_instr, 32'h0000_0013);
        check("unsup_err", out_err, 1);
        cycle(0, 1, 0, acc);
        check("unsup_err_count", err_count, RC + 1);

        // Flush
        cycle(0, 0, 1, acc);
        rand_req(1'b1); cycle(1, 0, 0, acc);
        rand_req(1'b1); cycle(1, 0, 0, acc);
        rand_req(1'b1);
        cycle(1, 0, 1, acc);
        check("flush_drop", acc, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_err_count", err_count, RC + 1);
        cycle(1, 0, 0, acc);
        check("flush_addr", out_addr, 0);
        cycle(0, 1, 0, acc);

        // Random traffic
        pend = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            bit ord, clr;
            if (!pend && ($urandom % 4 != 0)) begin
                rand_req(1'b0);
                pend = 1'b1;
            end
            ord = ($urandom % 3 != 0);
            clr = ($urandom % 64 == 0);
            cycle(pend, ord, clr, acc);
            if (acc) pend = 1'b0;
        end
        check("err_count_saturated", err_count, 255);

        // Reset with words buffered
        k = 0;
        while (exp_q.size() < 2 && k < 10) begin
            rand_req(1'b1);
            cycle(1, 0, 0, acc);
            k++;
        end
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_err_count", err_count, 0);
        exp_q.delete();
        model_addr = 0;
        n_err = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rand_req(1'b1);
        cycle(1, 0, 0, acc);
        check("midrst_addr", out_addr, 0);
        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            cycle(0, 1, 0, acc);
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
        check("final_out_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
